fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the RV32I pipeline. It owns the fetch PC, drives a request/acknowledge handshake to a multi-cycle instruction memory, and holds the IF/ID pipeline register, including a one-entry skid buffer. Branch redirects flush in-flight fetches. It replaces the free-running PC/IF_ID pair so that IMEM wait states, hazard stalls and redirects are sequenced in one place.

---
 rtl/rv32i_pkg.sv | 14 +
 rtl/fetch_skid_buf.sv | 54 +++++
 rtl/fetch_ctrl.sv | 172 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I constants and fetch-state encoding
package rv32i_pkg;

    localparam logic [31:0] NOP_INSN = 32'h00000013;
    localparam int          PC_STEP  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {ins, pc} holding buffer for acked fetches
module fetch_skid_buf
    import rv32i_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            pop,
    input  logic            flush,
    input  logic [31:0]     ins_in,
    input  logic [PC_W-1:0] pc_in,
    output logic            valid,
    output logic [31:0]     ins,
    output logic [PC_W-1:0] pc
);

    logic            valid_q, valid_d;
    logic [31:0]     ins_q, ins_d;
    logic [PC_W-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        ins_d   = ins_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            ins_d   = ins_in;
            pc_d    = pc_in;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ins_q   <= NOP_INSN;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ins_q   <= ins_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign ins   = ins_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch PC sequencer with IMEM req/ack handshake and IF/ID register
module fetch_ctrl
    import rv32i_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] pc_f,
    output logic [31:0]     ins_d,
    output logic [PC_W-1:0] pc_d,
    output logic [PC_W-1:0] pc_next_d,
    output logic            valid_d
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_f_q, pc_f_d;
    logic [PC_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]     ins_d_q, ins_d_d;
    logic [PC_W-1:0] pc_d_q, pc_d_d;
    logic [PC_W-1:0] pc_next_d_q, pc_next_d_d;
    logic            valid_d_q, valid_d_d;

    logic            buf_load, buf_pop, buf_flush, buf_valid;
    logic [31:0]     buf_ins;
    logic [PC_W-1:0] buf_pc;
    logic [PC_W-1:0] pc_inc;

    assign pc_inc = pc_f_q + PC_W'(PC_STEP);

    fetch_skid_buf #(.PC_W(PC_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (buf_load),
        .pop    (buf_pop),
        .flush  (buf_flush),
        .ins_in (imem_rdata),
        .pc_in  (imem_addr_q),
        .valid  (buf_valid),
        .ins    (buf_ins),
        .pc     (buf_pc)
    );

    // A started request stays up until acked, whatever the hazard inputs do.
    always_comb begin
        state_d     = state_q;
        pc_f_d      = pc_f_q;
        imem_addr_d = imem_addr_q;
        buf_load    = 1'b0;
        buf_pop     = 1'b0;
        buf_flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_f_d = redirect_pc;
                end else if (!stall_f) begin
                    state_d     = FETCH;
                    imem_addr_d = pc_f_q;
                end
            end
            FETCH: begin
                if (redirect) begin
                    pc_f_d  = redirect_pc;
                    state_d = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    pc_f_d = pc_inc;
                    if (stall_d) begin
                        buf_load = 1'b1;
                        state_d  = FULL;
                    end else if (stall_f) begin
                        state_d = IDLE;
                    end else begin
                        imem_addr_d = pc_inc;
                    end
                end
            end
            FULL: begin
                if (redirect) begin
                    buf_flush = 1'b1;
                    pc_f_d    = redirect_pc;
                    state_d   = IDLE;
                end else if (!stall_d) begin
                    buf_pop = 1'b1;
                    if (stall_f) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = FETCH;
                        imem_addr_d = pc_f_q;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    pc_f_d = redirect_pc;
                end
                if (imem_ack) begin
                    if (stall_f || redirect) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = FETCH;
                        imem_addr_d = pc_f_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ins_d_d     = ins_d_q;
        pc_d_d      = pc_d_q;
        pc_next_d_d = pc_next_d_q;
        valid_d_d   = valid_d_q;
        if (redirect) begin
            valid_d_d = 1'b0;
            ins_d_d   = NOP_INSN;
        end else if (!stall_d) begin
            if (state_q == FETCH && imem_ack) begin
                valid_d_d   = 1'b1;
                ins_d_d     = imem_rdata;
                pc_d_d      = imem_addr_q;
                pc_next_d_d = imem_addr_q + PC_W'(PC_STEP);
            end else if (state_q == FULL && buf_valid) begin
                valid_d_d   = 1'b1;
                ins_d_d     = buf_ins;
                pc_d_d      = buf_pc;
                pc_next_d_d = buf_pc + PC_W'(PC_STEP);
            end else begin
                valid_d_d = 1'b0;
                ins_d_d   = NOP_INSN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_f_q      <= RESET_PC;
            imem_addr_q <= '0;
            ins_d_q     <= NOP_INSN;
            pc_d_q      <= '0;
            pc_next_d_q <= '0;
            valid_d_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_f_q      <= pc_f_d;
            imem_addr_q <= imem_addr_d;
            ins_d_q     <= ins_d_d;
            pc_d_q      <= pc_d_d;
            pc_next_d_q <= pc_next_d_d;
            valid_d_q   <= valid_d_d;
        end
    end

    assign imem_req  = (state_q == FETCH) || (state_q == DROP);
    assign imem_addr = imem_addr_q;
    assign pc_f      = pc_f_q;
    assign ins_d     = ins_d_q;
    assign pc_d      = pc_d_q;
    assign pc_next_d = pc_next_d_q;
    assign valid_d   = valid_d_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed vector bench for fetch_ctrl
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f, stall_d, redirect;
    logic [7:0]  redirect_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [7:0]  pc_f;
    logic [31:0] ins_d;
    logic [7:0]  pc_d;
    logic [7:0]  pc_next_d;
    logic        valid_d;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Memory word encodes its own address so a wrong or duplicated PC shows up in ins_d.
    assign imem_rdata = imem_ack ? {24'hC00000, imem_addr} : 32'hDEADBEEF;

    fetch_ctrl #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc_f        (pc_f),
        .ins_d       (ins_d),
        .pc_d        (pc_d),
        .pc_next_d   (pc_next_d),
        .valid_d     (valid_d)
    );

    typedef struct {
        logic       sf, sd, rd;
        logic [7:0] rpc;
        logic       ack;
        logic       req;
        logic [7:0] addr, pcf;
        logic       vd;
        logic [7:0] pcd, pnd;
    } vec_t;

    vec_t vecs[34];

    function automatic vec_t mk(logic sf, logic sd, logic rd, logic [7:0] rpc, logic ack,
                                logic req, logic [7:0] addr, logic [7:0] pcf, logic vd,
                                logic [7:0] pcd, logic [7:0] pnd);
        vec_t v;
        v.sf = sf; v.sd = sd; v.rd = rd; v.rpc = rpc; v.ack = ack;
        v.req = req; v.addr = addr; v.pcf = pcf; v.vd = vd; v.pcd = pcd; v.pnd = pnd;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %08h expected %08h", name, idx, act, exp);
        end
    endtask

    task automatic chk_reset(input int idx);
        chk("rst_req",   idx, {31'd0, imem_req}, 32'd0);
        chk("rst_addr",  idx, {24'd0, imem_addr}, 32'd0);
        chk("rst_pcf",   idx, {24'd0, pc_f}, 32'd0);
        chk("rst_valid", idx, {31'd0, valid_d}, 32'd0);
        chk("rst_ins",   idx, ins_d, NOP);
        chk("rst_pcd",   idx, {24'd0, pc_d}, 32'd0);
        chk("rst_pnd",   idx, {24'd0, pc_next_d}, 32'd0);
    endtask

    initial begin
        //            sf sd rd rpc    ack  req addr   pcf    vd pcd    pnd
        vecs[0]  = mk(0, 0, 0, 8'h00, 1,   0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        vecs[1]  = mk(0, 0, 0, 8'h00, 1,   1, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        vecs[2]  = mk(0, 0, 0, 8'h00, 1,   1, 8'h04, 8'h04, 1, 8'h00, 8'h04);
        vecs[3]  = mk(0, 0, 0, 8'h00, 0,   1, 8'h08, 8'h08, 1, 8'h04, 8'h08);
        vecs[4]  = mk(0, 0, 0, 8'h00, 0,   1, 8'h08, 8'h08, 0, 8'h04, 8'h08);
        vecs[5]  = mk(0, 0, 0, 8'h00, 1,   1, 8'h08, 8'h08, 0, 8'h04, 8'h08);
        vecs[6]  = mk(0, 1, 0, 8'h00, 1,   1, 8'h0C, 8'h0C, 1, 8'h08, 8'h0C);
        vecs[7]  = mk(0, 1, 0, 8'h00, 1,   0, 8'h0C, 8'h10, 1, 8'h08, 8'h0C);
        vecs[8]  = mk(0, 1, 0, 8'h00, 1,   0, 8'h0C, 8'h10, 1, 8'h08, 8'h0C);
        vecs[9]  = mk(0, 0, 0, 8'h00, 1,   0, 8'h0C, 8'h10, 1, 8'h08, 8'h0C);
        vecs[10] = mk(0, 0, 0, 8'h00, 0,   1, 8'h10, 8'h10, 1, 8'h0C, 8'h10);
        vecs[11] = mk(0, 0, 1, 8'h40, 0,   1, 8'h10, 8'h10, 0, 8'h0C, 8'h10);
        vecs[12] = mk(0, 0, 0, 8'h00, 0,   1, 8'h10, 8'h40, 0, 8'h0C, 8'h10);
        vecs[13] = mk(0, 0, 0, 8'h00, 1,   1, 8'h10, 8'h40, 0, 8'h0C, 8'h10);
        vecs[14] = mk(0, 0, 0, 8'h00, 1,   1, 8'h40, 8'h40, 0, 8'h0C, 8'h10);
        vecs[15] = mk(0, 0, 0, 8'h00, 1,   1, 8'h44, 8'h44, 1, 8'h40, 8'h44);
        vecs[16] = mk(0, 1, 1, 8'h80, 1,   1, 8'h48, 8'h48, 1, 8'h44, 8'h48);
        vecs[17] = mk(0, 0, 0, 8'h00, 0,   0, 8'h48, 8'h80, 0, 8'h44, 8'h48);
        vecs[18] = mk(0, 0, 0, 8'h00, 1,   1, 8'h80, 8'h80, 0, 8'h44, 8'h48);
        vecs[19] = mk(0, 0, 1, 8'hFC, 0,   1, 8'h84, 8'h84, 1, 8'h80, 8'h84);
        vecs[20] = mk(0, 0, 0, 8'h00, 1,   1, 8'h84, 8'hFC, 0, 8'h80, 8'h84);
        vecs[21] = mk(0, 0, 0, 8'h00, 1,   1, 8'hFC, 8'hFC, 0, 8'h80, 8'h84);
        vecs[22] = mk(1, 0, 0, 8'h00, 1,   1, 8'h00, 8'h00, 1, 8'hFC, 8'h00);
        vecs[23] = mk(1, 0, 0, 8'h00, 0,   0, 8'h00, 8'h04, 1, 8'h00, 8'h04);
        vecs[24] = mk(1, 0, 1, 8'h20, 0,   0, 8'h00, 8'h04, 0, 8'h00, 8'h04);
        vecs[25] = mk(0, 0, 0, 8'h00, 0,   0, 8'h00, 8'h20, 0, 8'h00, 8'h04);
        vecs[26] = mk(1, 0, 0, 8'h00, 0,   1, 8'h20, 8'h20, 0, 8'h00, 8'h04);
        vecs[27] = mk(1, 0, 0, 8'h00, 1,   1, 8'h20, 8'h20, 0, 8'h00, 8'h04);
        vecs[28] = mk(0, 0, 0, 8'h00, 0,   0, 8'h20, 8'h24, 1, 8'h20, 8'h24);
        vecs[29] = mk(0, 1, 0, 8'h00, 1,   1, 8'h24, 8'h24, 0, 8'h20, 8'h24);
        vecs[30] = mk(0, 1, 1, 8'h60, 0,   0, 8'h24, 8'h28, 0, 8'h20, 8'h24);
        vecs[31] = mk(0, 0, 0, 8'h00, 0,   0, 8'h24, 8'h60, 0, 8'h20, 8'h24);
        vecs[32] = mk(0, 0, 0, 8'h00, 1,   1, 8'h60, 8'h60, 0, 8'h20, 8'h24);
        vecs[33] = mk(0, 0, 0, 8'h00, 0,   1, 8'h64, 8'h64, 1, 8'h60, 8'h64);

        rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; redirect = 1'b0;
        redirect_pc = 8'h00; imem_ack = 1'b1;
        @(posedge clk); #1;
        chk_reset(-1);
        @(posedge clk);

        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            rst         = 1'b0;
            stall_f     = vecs[i].sf;
            stall_d     = vecs[i].sd;
            redirect    = vecs[i].rd;
            redirect_pc = vecs[i].rpc;
            imem_ack    = vecs[i].ack;
            #1;
            chk("imem_req",  i, {31'd0, imem_req}, {31'd0, vecs[i].req});
            chk("imem_addr", i, {24'd0, imem_addr}, {24'd0, vecs[i].addr});
            chk("pc_f",      i, {24'd0, pc_f}, {24'd0, vecs[i].pcf});
            chk("valid_d",   i, {31'd0, valid_d}, {31'd0, vecs[i].vd});
            chk("pc_d",      i, {24'd0, pc_d}, {24'd0, vecs[i].pcd});
            chk("pc_next_d", i, {24'd0, pc_next_d}, {24'd0, vecs[i].pnd});
            chk("ins_d",     i, ins_d, vecs[i].vd ? (32'hC0000000 | {24'd0, vecs[i].pcd}) : NOP);
        end

        // Reset while a fetch is outstanding abandons it.
        @(negedge clk);
        rst = 1'b1; imem_ack = 1'b0; stall_f = 1'b0; stall_d = 1'b0; redirect = 1'b0;
        #1;
        chk("pre_rst_req", 34, {31'd0, imem_req}, 32'd1);
        @(posedge clk); #1;
        chk_reset(35);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
